dmem_bus_if: RTL

Data-memory bus master at the consuming end of the execute-stage load/store request. Takes the MEM-stage access (address from the ALU result, lane-replicated store data, size, sign-extend flag), drives one single-beat cycle on the data bus, and returns aligned, extended load data. Stalls the pipeline until the access retires. Flags misaligned accesses and bus errors or timeouts.

---
 rtl/dmem_bus_if.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_bus_if.sv
// Data-memory bus master: turns one MEM-stage load/store into a single-beat
// bus cycle, stalls the pipeline until it retires, and returns aligned,
// extended load data together with misalignment and bus-fault flags.
module dmem_bus_if #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_sz,
    input  logic        req_sx,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault_misalign,
    output logic        fault_bus,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 3 is illegal; half and word must be naturally aligned.
    function automatic logic f_misalign(input logic [1:0] sz, input logic [1:0] off);
        logic m;
        case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = off[0];
            2'd2:    m = (off != 2'd0);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Byte-lane enables for an aligned access.
    function automatic logic [3:0] f_byte_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Move the addressed lane down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sx);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> {off, 3'b000};
        case (sz)
            2'd0:    r = sx ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            2'd1:    r = sx ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic        killed_r, killed_s, kill_s;
    logic        we_r, we_s;
    logic [1:0]  sz_r, sz_s;
    logic        sx_r, sx_s;
    logic [1:0]  off_r, off_s;
    logic        bus_cyc_r, bus_cyc_s;
    logic        bus_we_r, bus_we_s;
    logic [29:0] bus_addr_r, bus_addr_s;
    logic [3:0]  bus_be_r, bus_be_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;
    logic [31:0] rdata_r, rdata_s;
    logic        done_r, done_s;
    logic        fault_mis_r, fault_mis_s;
    logic        fault_bus_r, fault_bus_s;

    // Next-state and next-register values for the access sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        killed_s    = killed_r;
        kill_s      = 1'b0;
        we_s        = we_r;
        sz_s        = sz_r;
        sx_s        = sx_r;
        off_s       = off_r;
        bus_cyc_s   = bus_cyc_r;
        bus_we_s    = bus_we_r;
        bus_addr_s  = bus_addr_r;
        bus_be_s    = bus_be_r;
        bus_wdata_s = bus_wdata_r;
        rdata_s     = rdata_r;
        done_s      = 1'b0;
        fault_mis_s = fault_mis_r;
        fault_bus_s = fault_bus_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    we_s     = req_we;
                    sz_s     = req_sz;
                    sx_s     = req_sx;
                    off_s    = req_addr[1:0];
                    killed_s = 1'b0;
                    if (f_misalign(req_sz, req_addr[1:0])) begin
                        state_s     = ST_RESP;
                        done_s      = 1'b1;
                        fault_mis_s = 1'b1;
                        fault_bus_s = 1'b0;
                        rdata_s     = 32'd0;
                    end else begin
                        state_s     = ST_BUS;
                        bus_cyc_s   = 1'b1;
                        bus_we_s    = req_we;
                        bus_addr_s  = req_addr[31:2];
                        bus_be_s    = f_byte_en(req_sz, req_addr[1:0]);
                        bus_wdata_s = req_wdata;
                        cnt_s       = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // A flush in the final bus cycle kills the access as well.
                kill_s = killed_r | flush;
                if (bus_err || bus_ack || (cnt_r == CNT_LAST)) begin
                    bus_cyc_s = 1'b0;
                    killed_s  = 1'b0;
                    if (kill_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s     = ST_RESP;
                        done_s      = 1'b1;
                        fault_mis_s = 1'b0;
                        if (bus_err) begin
                            fault_bus_s = 1'b1;
                            rdata_s     = 32'd0;
                        end else if (bus_ack) begin
                            fault_bus_s = 1'b0;
                            rdata_s     = we_r ? 32'd0 : f_extract(bus_rdata, off_r, sz_r, sx_r);
                        end else begin
                            fault_bus_s = 1'b1;
                            rdata_s     = 32'd0;
                        end
                    end
                end else begin
                    cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    killed_s = kill_s;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            killed_r    <= 1'b0;
            we_r        <= 1'b0;
            sz_r        <= 2'd0;
            sx_r        <= 1'b0;
            off_r       <= 2'd0;
            bus_cyc_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 30'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
            done_r      <= 1'b0;
            fault_mis_r <= 1'b0;
            fault_bus_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            killed_r    <= killed_s;
            we_r        <= we_s;
            sz_r        <= sz_s;
            sx_r        <= sx_s;
            off_r       <= off_s;
            bus_cyc_r   <= bus_cyc_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_be_r    <= bus_be_s;
            bus_wdata_r <= bus_wdata_s;
            rdata_r     <= rdata_s;
            done_r      <= done_s;
            fault_mis_r <= fault_mis_s;
            fault_bus_r <= fault_bus_s;
        end
    end

    assign stall          = (state_r == ST_BUS) | ((state_r == ST_IDLE) & req_valid & ~flush);
    assign done           = done_r;
    assign rdata          = rdata_r;
    assign fault_misalign = fault_mis_r;
    assign fault_bus      = fault_bus_r;
    assign bus_cyc        = bus_cyc_r;
    assign bus_we         = bus_we_r;
    assign bus_addr       = bus_addr_r;
    assign bus_be         = bus_be_r;
    assign bus_wdata      = bus_wdata_r;

endmodule
